// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-buffer FSM states and
// constants common to the UART and its receive buffer.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      ACK
   } rx_buf_state_t;

   localparam int UART_DATA_WIDTH = 8;
   localparam int CLKS_PER_BIT    = 434;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Byte handshake between the UART receiver and the receive buffer.
// The UART drives the byte and flags; the buffer drives the acknowledge.
interface uart_rx_buffer_if
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
);

   logic                  RxInterrupt;
   logic [DATA_WIDTH-1:0] ReceivedData;
   logic                  ParityError;
   logic                  ClearInterrupt;

   modport master (
      output RxInterrupt,
      output ReceivedData,
      output ParityError,
      input  ClearInterrupt
   );

   modport slave (
      input  RxInterrupt,
      input  ReceivedData,
      input  ParityError,
      output ClearInterrupt
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered
// occupancy and flags.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DATA_WIDTH-1:0]      pushData,
   input  logic                       pop,
   output logic [DATA_WIDTH-1:0]      popData,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wrPtr;
   logic [AW-1:0]         rdPtr;
   logic                  doPush;
   logic                  doPop;
   logic [CW-1:0]         countNext;

   // A push into a full FIFO is legal only when a pop frees the slot.
   assign doPop  = pop & ~empty;
   assign doPush = push & (~full | doPop);

   assign popData = mem[rdPtr];

   always_comb begin
      countNext = count;
      if (doPush && !doPop) begin
         countNext = count + 1'b1;
      end else if (doPop && !doPush) begin
         countNext = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= pushData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         count <= countNext;
         empty <= (countNext == '0);
         full  <= (countNext == FULL_CNT);
      end
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer behind the UART: one byte per interrupt, good bytes
// queued, parity-error and overflow bytes dropped and counted.
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   uart_rx_buffer_if.slave          rxIf,
   input  logic                     PopData,
   output logic [DATA_WIDTH-1:0]    FifoData,
   output logic                     FifoEmpty,
   output logic                     FifoFull,
   output logic [$clog2(DEPTH):0]   FifoCount,
   output logic [CNT_WIDTH-1:0]     ParityErrCount,
   output logic [CNT_WIDTH-1:0]     OverflowCount
);

   rx_buf_state_t         state;
   rx_buf_state_t         stateNext;
   logic [DATA_WIDTH-1:0] holdData;
   logic                  holdParity;
   logic                  push;
   logic                  parityInc;
   logic                  overflowInc;

   always_comb begin
      stateNext   = state;
      push        = 1'b0;
      parityInc   = 1'b0;
      overflowInc = 1'b0;
      unique case (state)
         IDLE: begin
            if (rxIf.RxInterrupt) begin
               stateNext = CAPTURE;
            end
         end
         CAPTURE: begin
            stateNext = ACK;
            // A pop in this cycle frees a slot, so a full FIFO still accepts.
            if (holdParity) begin
               parityInc = 1'b1;
            end else if (FifoFull && !PopData) begin
               overflowInc = 1'b1;
            end else begin
               push = 1'b1;
            end
         end
         ACK: begin
            if (!rxIf.RxInterrupt) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         rxIf.ClearInterrupt <= 1'b0;
         holdData            <= '0;
         holdParity          <= 1'b0;
         ParityErrCount      <= '0;
         OverflowCount       <= '0;
      end else begin
         state               <= stateNext;
         rxIf.ClearInterrupt <= (stateNext == ACK);
         if (state == IDLE && rxIf.RxInterrupt) begin
            holdData   <= rxIf.ReceivedData;
            holdParity <= rxIf.ParityError;
         end
         if (parityInc && ParityErrCount != '1) begin
            ParityErrCount <= ParityErrCount + 1'b1;
         end
         if (overflowInc && OverflowCount != '1) begin
            OverflowCount <= OverflowCount + 1'b1;
         end
      end
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) uFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pushData (holdData),
      .pop      (PopData),
      .popData  (FifoData),
      .full     (FifoFull),
      .empty    (FifoEmpty),
      .count    (FifoCount)
   );

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed vector table plus hand-written multi-cycle sequences
// for the UART receive buffer.
module tb_uart_rx_buffer;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       PopData;
   logic [7:0] FifoData;
   logic       FifoEmpty;
   logic       FifoFull;
   logic [4:0] FifoCount;
   logic [7:0] ParityErrCount;
   logic [7:0] OverflowCount;

   int nChecks = 0;
   int nMis    = 0;

   uart_rx_buffer_if rxIf ();

   uart_rx_buffer #(
      .DATA_WIDTH (8),
      .DEPTH      (16),
      .CNT_WIDTH  (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rxIf           (rxIf),
      .PopData        (PopData),
      .FifoData       (FifoData),
      .FifoEmpty      (FifoEmpty),
      .FifoFull       (FifoFull),
      .FifoCount      (FifoCount),
      .ParityErrCount (ParityErrCount),
      .OverflowCount  (OverflowCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       rx;
      logic [7:0] d;
      logic       par;
      logic       pop;
      logic [4:0] cnt;
      logic       emp;
      logic       ful;
      logic       clr;
      logic       chkD;
      logic [7:0] expD;
      logic [7:0] parC;
      logic [7:0] ovfC;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      rxIf.RxInterrupt = 1'b0;
      PopData = 1'b0;
      step();
      reset = 1'b0;
   endtask

   // Full handshake for one byte; popCap is driven during CAPTURE.
   task automatic sendByte(input logic [7:0] d, input logic p,
                           input logic popCap);
      rxIf.RxInterrupt  = 1'b1;
      rxIf.ReceivedData = d;
      rxIf.ParityError  = p;
      step();
      chk("clrInCapture", rxIf.ClearInterrupt, 0);
      PopData = popCap;
      step();
      PopData = 1'b0;
      chk("clrInAck", rxIf.ClearInterrupt, 1);
      rxIf.RxInterrupt = 1'b0;
      step();
      chk("clrReleased", rxIf.ClearInterrupt, 0);
   endtask

   task automatic popOne(input logic [7:0] exp);
      chk("popData", FifoData, exp);
      PopData = 1'b1;
      step();
      PopData = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      PopData = 1'b0;
      rxIf.RxInterrupt  = 1'b0;
      rxIf.ReceivedData = '0;
      rxIf.ParityError  = 1'b0;

      //            rst rx  d      par pop cnt emp ful clr chkD expD  parC ovfC
      vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0};
      vecs[1]  = '{0, 1, 8'h55, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0};
      vecs[2]  = '{0, 1, 8'h55, 0, 0, 1, 0, 0, 1, 1, 8'h55, 0, 0};
      vecs[3]  = '{0, 1, 8'h55, 0, 0, 1, 0, 0, 1, 1, 8'h55, 0, 0};
      vecs[4]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 8'h55, 0, 0};
      vecs[5]  = '{0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0};
      vecs[6]  = '{0, 1, 8'hA3, 1, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0};
      vecs[7]  = '{0, 1, 8'hA3, 1, 0, 0, 1, 0, 1, 0, 8'h00, 1, 0};
      vecs[8]  = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0};
      vecs[9]  = '{0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h00, 1, 0};
      vecs[10] = '{0, 1, 8'h3C, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0};
      vecs[11] = '{0, 1, 8'h3C, 0, 0, 1, 0, 0, 1, 1, 8'h3C, 1, 0};
      vecs[12] = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 8'h3C, 1, 0};
      vecs[13] = '{0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h00, 1, 0};

      for (int i = 0; i < 14; i++) begin
         reset             = vecs[i].rst;
         rxIf.RxInterrupt  = vecs[i].rx;
         rxIf.ReceivedData = vecs[i].d;
         rxIf.ParityError  = vecs[i].par;
         PopData           = vecs[i].pop;
         step();
         chk($sformatf("v%0d.count", i), FifoCount, vecs[i].cnt);
         chk($sformatf("v%0d.empty", i), FifoEmpty, vecs[i].emp);
         chk($sformatf("v%0d.full", i), FifoFull, vecs[i].ful);
         chk($sformatf("v%0d.clr", i), rxIf.ClearInterrupt, vecs[i].clr);
         chk($sformatf("v%0d.parCnt", i), ParityErrCount, vecs[i].parC);
         chk($sformatf("v%0d.ovfCnt", i), OverflowCount, vecs[i].ovfC);
         if (vecs[i].chkD) begin
            chk($sformatf("v%0d.data", i), FifoData, vecs[i].expD);
         end
      end
      PopData = 1'b0;
      rxIf.RxInterrupt = 1'b0;

      // Fill, overflow, drain in order.
      doReset();
      for (int i = 0; i < 16; i++) begin
         sendByte(8'(i), 1'b0, 1'b0);
      end
      chk("fill.count", FifoCount, 16);
      chk("fill.full", FifoFull, 1);
      sendByte(8'hFF, 1'b0, 1'b0);
      chk("ovf.count", FifoCount, 16);
      chk("ovf.ovfCnt", OverflowCount, 1);
      for (int i = 0; i < 16; i++) begin
         popOne(8'(i));
      end
      chk("drain.empty", FifoEmpty, 1);
      chk("drain.count", FifoCount, 0);

      // Push while full with a pop in the capture cycle.
      doReset();
      for (int i = 0; i < 16; i++) begin
         sendByte(8'(i), 1'b0, 1'b0);
      end
      chk("fullPop.head", FifoData, 8'h00);
      sendByte(8'h10, 1'b0, 1'b1);
      chk("fullPop.count", FifoCount, 16);
      chk("fullPop.full", FifoFull, 1);
      chk("fullPop.ovfCnt", OverflowCount, 0);
      for (int i = 1; i < 16; i++) begin
         popOne(8'(i));
      end
      popOne(8'h10);
      chk("fullPop.empty", FifoEmpty, 1);

      // Reset during ACK with RxInterrupt still high.
      doReset();
      sendByte(8'h11, 1'b0, 1'b0);
      sendByte(8'h22, 1'b0, 1'b0);
      sendByte(8'hE1, 1'b1, 1'b0);
      sendByte(8'hE2, 1'b1, 1'b0);
      rxIf.RxInterrupt  = 1'b1;
      rxIf.ReceivedData = 8'h77;
      rxIf.ParityError  = 1'b0;
      step();
      step();
      chk("midAck.count", FifoCount, 3);
      chk("midAck.parCnt", ParityErrCount, 2);
      chk("midAck.clr", rxIf.ClearInterrupt, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst.clr", rxIf.ClearInterrupt, 0);
      chk("rst.count", FifoCount, 0);
      chk("rst.empty", FifoEmpty, 1);
      chk("rst.parCnt", ParityErrCount, 0);
      step();
      step();
      chk("recap.count", FifoCount, 1);
      chk("recap.data", FifoData, 8'h77);
      chk("recap.clr", rxIf.ClearInterrupt, 1);
      rxIf.RxInterrupt = 1'b0;
      step();

      // Parity counter saturates at its maximum.
      doReset();
      for (int i = 0; i < 256; i++) begin
         rxIf.RxInterrupt  = 1'b1;
         rxIf.ReceivedData = 8'h5A;
         rxIf.ParityError  = 1'b1;
         step();
         step();
         rxIf.RxInterrupt = 1'b0;
         step();
         if (i == 254) begin
            chk("sat.pre", ParityErrCount, 255);
         end
      end
      chk("sat.parCnt", ParityErrCount, 255);
      chk("sat.count", FifoCount, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMis);
      $finish;
   end

endmodule
